fir_tap_buffer_pingpong: RTL and testbench

// Double-buffered (ping-pong) serial-to-parallel tap buffer for the FIR HWPE.

---
 rtl/fir_tap_buffer_pingpong.sv | 110 +++++++++++
 tb/tb_fir_tap_buffer_pingpong.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_buffer_pingpong.sv
// Ping-pong serial-to-parallel coefficient buffer: one bank fills from the serial
// stream while the other is presented in parallel until the consumer releases it.
module fir_tap_buffer_pingpong #(
  parameter int DATA_WIDTH  = 32,
  parameter int NB_TAPS_MAX = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  clear_i,
  input  logic [$clog2(NB_TAPS_MAX+1)-1:0]      nb_taps_i,
  input  logic [DATA_WIDTH-1:0]                 h_serial_data_i,
  input  logic                                  h_serial_valid_i,
  output logic                                  h_serial_ready_o,
  output logic [NB_TAPS_MAX*DATA_WIDTH-1:0]     h_par_data_o,
  output logic                                  h_par_valid_o,
  input  logic                                  h_par_ready_i,
  output logic [$clog2(NB_TAPS_MAX+1)-1:0]      fill_count_o,
  output logic [1:0]                            nb_full_o,
  output logic                                  done_o
);

  localparam int CW = $clog2(NB_TAPS_MAX+1);
  localparam int BW = NB_TAPS_MAX*DATA_WIDTH;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_e;

  bank_state_e     r_state [2];
  logic [CW-1:0]   r_ntaps [2];
  logic [BW-1:0]   r_bank  [2];
  logic            r_wr_bank;
  logic            r_rd_bank;
  logic [CW-1:0]   r_fill_count;
  logic            r_done;

  logic            w_wr_hs;
  logic            w_rd_hs;
  logic            w_last;
  logic [CW-1:0]   w_ntaps_eff;

  // A count of zero or anything above the bank size selects a full bank.
  function automatic logic [CW-1:0] clamp_taps(input logic [CW-1:0] n);
    if (n == '0 || n > CW'(NB_TAPS_MAX)) return CW'(NB_TAPS_MAX);
    return n;
  endfunction

  assign h_serial_ready_o = (r_state[r_wr_bank] != FULL);
  assign h_par_valid_o    = (r_state[r_rd_bank] == FULL);
  assign h_par_data_o     = r_bank[r_rd_bank];
  assign fill_count_o     = r_fill_count;
  assign done_o           = r_done;
  assign nb_full_o        = {1'b0, r_state[0] == FULL} + {1'b0, r_state[1] == FULL};

  assign w_wr_hs     = h_serial_valid_i && h_serial_ready_o;
  assign w_rd_hs     = h_par_valid_o && h_par_ready_i;
  // The first tap of a set uses the live count; later taps use the latched one.
  assign w_ntaps_eff = (r_state[r_wr_bank] == EMPTY) ? clamp_taps(nb_taps_i)
                                                     : r_ntaps[r_wr_bank];
  assign w_last      = (r_fill_count == w_ntaps_eff - CW'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state[0]   <= EMPTY;
      r_state[1]   <= EMPTY;
      r_ntaps[0]   <= '0;
      r_ntaps[1]   <= '0;
      r_bank[0]    <= '0;
      r_bank[1]    <= '0;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_fill_count <= '0;
      r_done       <= 1'b0;
    end else if (clear_i) begin
      r_state[0]   <= EMPTY;
      r_state[1]   <= EMPTY;
      r_ntaps[0]   <= '0;
      r_ntaps[1]   <= '0;
      r_bank[0]    <= '0;
      r_bank[1]    <= '0;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_fill_count <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_wr_hs && w_last;
      // Read and write never target the same bank in one cycle: the read bank
      // must be FULL and the write bank must not be.
      if (w_rd_hs) begin
        r_bank[r_rd_bank]  <= '0;
        r_state[r_rd_bank] <= EMPTY;
        r_rd_bank          <= ~r_rd_bank;
      end
      if (w_wr_hs) begin
        for (int k = 0; k < NB_TAPS_MAX; k++) begin
          if (CW'(k) == r_fill_count)
            r_bank[r_wr_bank][k*DATA_WIDTH +: DATA_WIDTH] <= h_serial_data_i;
        end
        if (r_state[r_wr_bank] == EMPTY) r_ntaps[r_wr_bank] <= w_ntaps_eff;
        if (w_last) begin
          r_state[r_wr_bank] <= FULL;
          r_wr_bank          <= ~r_wr_bank;
          r_fill_count       <= '0;
        end else begin
          r_state[r_wr_bank] <= FILLING;
          r_fill_count       <= r_fill_count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_buffer_pingpong.sv
// Directed and randomized-backpressure bench for the ping-pong tap buffer.
module tb_fir_tap_buffer_pingpong;

  localparam int DW = 32;
  localparam int NT = 8;
  localparam int BUDGET = 20000;

  logic           clk;
  logic           rst_n;
  logic           clear;
  logic [3:0]     nb_taps;
  logic [DW-1:0]  s_data;
  logic           s_valid;
  logic           s_ready;
  logic [NT*DW-1:0] p_data;
  logic           p_valid;
  logic           p_ready;
  logic [3:0]     fill_count;
  logic [1:0]     nb_full;
  logic           done;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int got    = 0;
  logic [NT*DW-1:0] sb [$];

  fir_tap_buffer_pingpong #(.DATA_WIDTH(DW), .NB_TAPS_MAX(NT)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .clear_i          (clear),
    .nb_taps_i        (nb_taps),
    .h_serial_data_i  (s_data),
    .h_serial_valid_i (s_valid),
    .h_serial_ready_o (s_ready),
    .h_par_data_o     (p_data),
    .h_par_valid_o    (p_valid),
    .h_par_ready_i    (p_ready),
    .fill_count_o     (fill_count),
    .nb_full_o        (nb_full),
    .done_o           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [NT*DW-1:0] obs, input logic [NT*DW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Expected parallel word: n consecutive taps starting at base, rest zero.
  function automatic logic [NT*DW-1:0] mk(input int n, input int base);
    logic [NT*DW-1:0] e;
    e = '0;
    for (int k = 0; k < n; k++) e[k*DW +: DW] = DW'(base + k);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic release_bank();
    p_ready = 1'b1;
    tick();
    p_ready = 1'b0;
  endtask

  task automatic producer();
    for (int s = 0; s < 100; s++) begin
      int n;
      int eff;
      logic [DW-1:0] tp [NT];
      logic [NT*DW-1:0] e;
      logic v;
      logic hs;
      n   = $urandom_range(0, 10);
      eff = (n == 0 || n > NT) ? NT : n;
      e   = '0;
      for (int i = 0; i < eff; i++) begin
        tp[i] = $urandom;
        e[i*DW +: DW] = tp[i];
      end
      sb.push_back(e);
      for (int i = 0; i < eff; i++) begin
        do begin
          v       = ($urandom_range(0, 3) != 0);
          s_valid = v;
          s_data  = tp[i];
          nb_taps = 4'(n);
          hs      = v && s_ready;
          tick();
        end while (!hs && cyc < BUDGET);
        if (cyc >= BUDGET) begin
          s_valid = 1'b0;
          return;
        end
      end
      s_valid = 1'b0;
    end
  endtask

  task automatic consumer();
    logic r;
    while (got < 100 && cyc < BUDGET) begin
      r       = ($urandom_range(0, 2) != 0);
      p_ready = r;
      if (r && p_valid) begin
        if (sb.size() == 0) chk("sb_extra", 1, 0);
        else chk("sb_set", p_data, sb.pop_front());
        got++;
      end
      tick();
    end
    p_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; nb_taps = '0; s_data = '0; s_valid = 1'b0; p_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",   s_ready, 1);
    chk("rst_valid",   p_valid, 0);
    chk("rst_nb_full", nb_full, 0);
    chk("rst_fill",    fill_count, 0);
    chk("rst_done",    done, 0);
    chk("rst_data",    p_data, 0);
    rst_n = 1'b1;
    tick();

    // single 4-tap set, consumer holds off
    nb_taps = 4'd4;
    send(1); send(2);
    chk("fill_mid", fill_count, 2);
    send(3);
    chk("valid_early", p_valid, 0);
    send(4);
    chk("t1_valid",   p_valid, 1);
    chk("t1_done",    done, 1);
    chk("t1_data",    p_data, mk(4, 1));
    chk("t1_nb_full", nb_full, 1);
    chk("t1_fill",    fill_count, 0);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_hold",       p_data, mk(4, 1));

    // second bank filled, both full
    send(5); send(6); send(7); send(8);
    chk("full2_ready",   s_ready, 0);
    chk("full2_nb_full", nb_full, 2);
    chk("full2_data",    p_data, mk(4, 1));
    release_bank();
    chk("rel_data",    p_data, mk(4, 5));
    chk("rel_valid",   p_valid, 1);
    chk("rel_ready",   s_ready, 1);
    chk("rel_nb_full", nb_full, 1);

    // last write into bank0 coincides with release of bank1
    send(9); send(10); send(11);
    p_ready = 1'b1;
    send(12);
    p_ready = 1'b0;
    chk("sim_valid",   p_valid, 1);
    chk("sim_data",    p_data, mk(4, 9));
    chk("sim_nb_full", nb_full, 1);
    chk("sim_ready",   s_ready, 1);
    release_bank();
    chk("drain_valid",   p_valid, 0);
    chk("drain_nb_full", nb_full, 0);

    // nb_taps = 0 means a full bank
    nb_taps = 4'd0;
    for (int i = 0; i < 7; i++) send(DW'('h21 + i));
    chk("nt0_valid7", p_valid, 0);
    chk("nt0_fill7",  fill_count, 7);
    send(32'h28);
    chk("nt0_valid8", p_valid, 1);
    chk("nt0_data",   p_data, mk(8, 'h21));
    release_bank();

    // count change mid-fill is ignored
    nb_taps = 4'd2;
    send(32'h31);
    nb_taps = 4'd6;
    send(32'h32);
    chk("ntchg_valid", p_valid, 1);
    chk("ntchg_data",  p_data, mk(2, 'h31));
    release_bank();

    // random backpressure scoreboard
    fork
      producer();
      consumer();
    join
    chk("rand_sets", got, 100);
    chk("rand_sb_empty", sb.size(), 0);
    tick();

    // clear mid-fill, overriding a same-cycle handshake
    nb_taps = 4'd4;
    send(32'h51); send(32'h52); send(32'h53);
    clear   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hEE;
    tick();
    clear   = 1'b0;
    s_valid = 1'b0;
    chk("clr_fill",    fill_count, 0);
    chk("clr_ready",   s_ready, 1);
    chk("clr_valid",   p_valid, 0);
    chk("clr_nb_full", nb_full, 0);
    chk("clr_done",    done, 0);
    tick();
    chk("clr_done2",   done, 0);
    send(32'h41); send(32'h42); send(32'h43); send(32'h44);
    chk("post_clr_valid", p_valid, 1);
    chk("post_clr_data",  p_data, mk(4, 'h41));
    chk("post_clr_done",  done, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
